// File: rtl/reset_sequencer_if.sv
// Bundle of reset-request inputs and sequenced reset outputs shared by
// the reset_sequencer and whatever drives its request side.
interface reset_sequencer_if #(
   parameter int NUM_SRC     = 2,
   parameter int NUM_DOMAINS = 3
);
   logic                   ext_resetn;
   logic [NUM_SRC-1:0]     req;
   logic                   cause_clr;
   logic [NUM_DOMAINS-1:0] domain_reset;
   logic                   all_released;
   logic                   busy;
   logic [NUM_SRC+1:0]     cause;

   modport master (
      output ext_resetn, req, cause_clr,
      input  domain_reset, all_released, busy, cause
   );

   modport slave (
      input  ext_resetn, req, cause_clr,
      output domain_reset, all_released, busy, cause
   );
endinterface

// File: rtl/reset_sequencer.sv
// Merges power-on, external and strobe reset sources into NUM_DOMAINS
// synchronous resets, asserted together and released in index order.
module reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_SRC     = 2,
   parameter int NUM_DOMAINS = 3,
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 4
) (
   input logic               clk,
   input logic               resetn,
   reset_sequencer_if.slave  bus
);
   localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW      = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);
   localparam int IW      = $clog2((NUM_DOMAINS > 2) ? NUM_DOMAINS : 2);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);
   localparam bit            ONE_SHOT  = (NUM_DOMAINS == 1) || (GAP_CYCLES == 0);

   typedef enum logic [1:0] {HOLD, RELEASE, DONE} state_t;

   logic [SYNC_STAGES-1:0] run_sync, ext_sync;
   logic                   run, ext_req, trigger;
   logic [NUM_SRC+1:0]     trig_bits;

   state_t                 state_q, state_d;
   logic [CW-1:0]          hold_q, hold_d, gap_q, gap_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic                   all_q, all_d, busy_q, busy_d;
   logic [NUM_SRC+1:0]     cause_q, cause_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run_sync <= '0;
         ext_sync <= '0;
      end else begin
         run_sync <= {run_sync[SYNC_STAGES-2:0], 1'b1};
         ext_sync <= {ext_sync[SYNC_STAGES-2:0], bus.ext_resetn};
      end
   end

   // Sources are ignored until the power-on release has propagated, so the
   // zero-reset external synchroniser does not log a spurious cause.
   assign run       = run_sync[SYNC_STAGES-1];
   assign ext_req   = ~ext_sync[SYNC_STAGES-1];
   assign trigger   = run & ((|bus.req) | ext_req);
   assign trig_bits = run ? {bus.req, ext_req, 1'b0} : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= HOLD;
         hold_q  <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '1;
         all_q   <= 1'b0;
         busy_q  <= 1'b1;
         cause_q <= (NUM_SRC+2)'(1);
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         all_q   <= all_d;
         busy_q  <= busy_d;
         cause_q <= cause_d;
      end
   end

   // NOTE: every variable gets a default before any branch, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      all_d   = all_q;
      busy_d  = busy_q;
      cause_d = (bus.cause_clr ? '0 : cause_q) | trig_bits;

      if (trigger) begin
         state_d = HOLD;
         hold_d  = '0;
         gap_d   = '0;
         idx_d   = '0;
         dom_d   = '1;
         all_d   = 1'b0;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            HOLD: begin
               if (run) begin
                  if (hold_q == HOLD_LAST) begin
                     hold_d = '0;
                     gap_d  = '0;
                     if (ONE_SHOT) begin
                        state_d = DONE;
                        dom_d   = '0;
                        all_d   = 1'b1;
                        busy_d  = 1'b0;
                     end else begin
                        state_d  = RELEASE;
                        dom_d[0] = 1'b0;
                        idx_d    = IW'(1);
                     end
                  end else begin
                     hold_d = hold_q + CW'(1);
                  end
               end
            end
            RELEASE: begin
               if (gap_q == GAP_LAST) begin
                  gap_d        = '0;
                  dom_d[idx_q] = 1'b0;
                  if (idx_q == IDX_LAST) begin
                     state_d = DONE;
                     idx_d   = '0;
                     all_d   = 1'b1;
                     busy_d  = 1'b0;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  gap_d = gap_q + CW'(1);
               end
            end
            DONE: ;
            default: begin
               state_d = HOLD;
               dom_d   = '1;
               all_d   = 1'b0;
               busy_d  = 1'b1;
            end
         endcase
      end
   end

   assign bus.domain_reset = dom_q;
   assign bus.all_released = all_q;
   assign bus.busy         = busy_q;
   assign bus.cause        = cause_q;
endmodule
